// File: rtl/khu_pad_io_cond.sv
// khu_pad_io_cond: pad-side conditioning between the pad ring and the sensor core.
// Provides a core reset synchroniser, synchronised/glitch-filtered input channels
// with edge pulses, and open-drain channels with registered enables, filtered
// readback and a sticky contention detector.
module khu_pad_io_cond #(
  parameter int              N_IN        = 4,
  parameter int              N_OD        = 2,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_LEN    = 3,
  parameter int              CONT_LEN    = 8,
  parameter logic [N_IN-1:0] IN_RST_VAL  = '1
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  output logic            o_RSTN_SYNC,
  input  logic [N_IN-1:0] i_pad_in,
  output logic [N_IN-1:0] o_in,
  output logic [N_IN-1:0] o_rise,
  output logic [N_IN-1:0] o_fall,
  input  logic [N_OD-1:0] i_od_drive_low,
  output logic [N_OD-1:0] o_od_tn,
  input  logic [N_OD-1:0] i_od_pad_y,
  output logic [N_OD-1:0] o_od_in,
  output logic [N_OD-1:0] o_od_contention,
  input  logic            i_clr_fault
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int CW = $clog2(CONT_LEN);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [CW-1:0] CONT_LAST = CW'(CONT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_rstSync;

  logic [N_IN-1:0] r_inSync [SYNC_STAGES];
  logic [FW-1:0]   r_inCnt  [N_IN];
  logic [N_IN-1:0] r_in;
  logic [N_IN-1:0] r_rise;
  logic [N_IN-1:0] r_fall;
  logic [N_IN-1:0] w_inS;
  logic [N_IN-1:0] w_inAccept;

  logic [N_OD-1:0] r_odTn;
  logic [N_OD-1:0] r_tnDly  [SYNC_STAGES];
  logic [N_OD-1:0] r_odSync [SYNC_STAGES];
  logic [FW-1:0]   r_odCnt  [N_OD];
  logic [N_OD-1:0] r_odIn;
  logic [N_OD-1:0] w_odS;
  logic [N_OD-1:0] w_odAccept;
  logic [N_OD-1:0] w_tnAligned;
  logic [N_OD-1:0] w_contCond;
  logic [N_OD-1:0] w_contSet;
  logic [CW-1:0]   r_contCnt [N_OD];
  logic [N_OD-1:0] r_contFlag;

  // Core reset: asserts with i_RSTN, releases after the chain fills with 1s.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) r_rstSync <= '0;
    else         r_rstSync <= {r_rstSync[SYNC_STAGES-2:0], 1'b1};
  end

  assign o_RSTN_SYNC = r_rstSync[SYNC_STAGES-1];

  // Input synchroniser chains, preloaded with each channel's idle level.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_inSync[i] <= IN_RST_VAL;
    end else begin
      r_inSync[0] <= i_pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_inSync[i] <= r_inSync[i-1];
    end
  end

  assign w_inS = r_inSync[SYNC_STAGES-1];

  // A new input level is accepted on the FILT_LEN-th consecutive disagreeing cycle.
  always_comb begin
    w_inAccept = '0;
    for (int b = 0; b < N_IN; b++)
      w_inAccept[b] = (w_inS[b] != r_in[b]) && (r_inCnt[b] == FILT_LAST);
  end

  // Input filter counters, filtered level and one-cycle edge pulses.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int b = 0; b < N_IN; b++) r_inCnt[b] <= '0;
      r_in   <= IN_RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int b = 0; b < N_IN; b++) begin
        if ((w_inS[b] == r_in[b]) || w_inAccept[b]) r_inCnt[b] <= '0;
        else                                        r_inCnt[b] <= r_inCnt[b] + 1'b1;
      end
      r_in   <= (r_in & ~w_inAccept) | (w_inS & w_inAccept);
      r_rise <= w_inAccept & w_inS;
      r_fall <= w_inAccept & ~w_inS;
    end
  end

  assign o_in   = r_in;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  // Registered active-low pad driver enable; drivers are off in reset.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) r_odTn <= '1;
    else         r_odTn <= ~i_od_drive_low;
  end

  assign o_od_tn = r_odTn;

  // Readback synchronisers plus a matching delay of the enable, so the contention
  // check compares drive and readback that belong to the same moment on the wire.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_odSync[i] <= '1;
        r_tnDly[i]  <= '1;
      end
    end else begin
      r_odSync[0] <= i_od_pad_y;
      r_tnDly[0]  <= r_odTn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_odSync[i] <= r_odSync[i-1];
        r_tnDly[i]  <= r_tnDly[i-1];
      end
    end
  end

  assign w_odS       = r_odSync[SYNC_STAGES-1];
  assign w_tnAligned = r_tnDly[SYNC_STAGES-1];

  // Readback acceptance plus the contention condition: driving low yet seeing high.
  always_comb begin
    w_odAccept = '0;
    w_contCond = '0;
    w_contSet  = '0;
    for (int b = 0; b < N_OD; b++) begin
      w_odAccept[b] = (w_odS[b] != r_odIn[b]) && (r_odCnt[b] == FILT_LAST);
      w_contCond[b] = ~w_tnAligned[b] & w_odS[b];
      w_contSet[b]  = w_contCond[b] && (r_contCnt[b] == CONT_LAST);
    end
  end

  // Readback filter counters and filtered readback level.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int b = 0; b < N_OD; b++) r_odCnt[b] <= '0;
      r_odIn <= '1;
    end else begin
      for (int b = 0; b < N_OD; b++) begin
        if ((w_odS[b] == r_odIn[b]) || w_odAccept[b]) r_odCnt[b] <= '0;
        else                                         r_odCnt[b] <= r_odCnt[b] + 1'b1;
      end
      r_odIn <= (r_odIn & ~w_odAccept) | (w_odS & w_odAccept);
    end
  end

  assign o_od_in = r_odIn;

  // Contention counters saturate; a pending set beats a simultaneous clear.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int b = 0; b < N_OD; b++) r_contCnt[b] <= '0;
      r_contFlag <= '0;
    end else begin
      for (int b = 0; b < N_OD; b++) begin
        if (!w_contCond[b])                r_contCnt[b] <= '0;
        else if (r_contCnt[b] != CONT_LAST) r_contCnt[b] <= r_contCnt[b] + 1'b1;
      end
      r_contFlag <= w_contSet | (r_contFlag & ~{N_OD{i_clr_fault}});
    end
  end

  assign o_od_contention = r_contFlag;

endmodule
